// File: rtl/rptr_empty_fwft_pkg.sv
// Pointer helpers shared by the async FIFO read/write controllers and synchronizers.
package rptr_empty_fwft_pkg;

    localparam int FN_W = 32;

    typedef logic [1:0] occ_t;

    // Callers zero-extend pointers to FN_W and cast the result back to pointer width.
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b = '0;
        for (int i = 0; i < FN_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_fwft_buf.sv
// Two-entry FWFT output/skid buffer fed by the RAM read port; reports occupancy incl. in-flight fetch.
// Latency: fill captured on the edge it arrives; backpressure: holds rdata/rvalid while rvalid && !rready.
module rptr_empty_fwft_buf
    import rptr_empty_fwft_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrstn,
    input  logic             fill,
    input  logic [DSIZE-1:0] fill_dat,
    input  logic             rready,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output occ_t             occ
);

    logic             out_vld_q, out_vld_d;
    logic [DSIZE-1:0] out_dat_q, out_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [DSIZE-1:0] skid_dat_q, skid_dat_d;
    logic             pop;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        pop        = out_vld_q & rready;
        if (pop) begin
            if (skid_vld_q) begin
                out_dat_d  = skid_dat_q;
                skid_vld_d = fill;
                if (fill) begin
                    skid_dat_d = fill_dat;
                end
            end else begin
                out_vld_d = fill;
                if (fill) begin
                    out_dat_d = fill_dat;
                end
            end
        end else if (fill) begin
            // Skid only ever fills behind a valid output word, so order is kept.
            if (!out_vld_q) begin
                out_vld_d = 1'b1;
                out_dat_d = fill_dat;
            end else begin
                skid_vld_d = 1'b1;
                skid_dat_d = fill_dat;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign rdata  = out_dat_q;
    assign rvalid = out_vld_q;
    assign occ    = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, fill};

endmodule

// File: rtl/rptr_empty_fwft.sv
// Async FIFO read side: read pointer, empty/level flags, credit-limited RAM fetch into FWFT buffer.
// Latency: new r_wptr to rvalid is 3 rclk; backpressure: fetch stops once buffer + in-flight reach 2.
module rptr_empty_fwft
    import rptr_empty_fwft_pkg::*;
#(
    parameter int ASIZE     = 4,
    parameter int DSIZE     = 8,
    parameter int AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrstn,
    input  logic [ASIZE:0]   r_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             mem_ren,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    input  logic             rready,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel
);

    localparam int PW = ASIZE + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic [PW-1:0] wbin;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          ren_q, ren_d;
    occ_t          occ;
    logic [2:0]    occ_after;

    always_comb begin
        // A pop this cycle frees a slot, so fetch can continue at full rate.
        occ_after = {1'b0, occ} - {2'b0, rvalid & rready};
        mem_ren   = !rempty_q && (occ_after < 3'd2);
        wbin      = PW'(gray2bin(FN_W'(r_wptr)));
        rbin_d    = rbin_q + PW'(mem_ren);
        rptr_d    = PW'(bin2gray(FN_W'(rbin_d)));
        rlevel_d  = wbin - rbin_d;
        rempty_d  = (rptr_d == r_wptr);
        raempty_d = (rlevel_d <= PW'(AE_THRESH));
        ren_d     = mem_ren;
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rlevel_q  <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            ren_q     <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rptr_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            raempty_q <= raempty_d;
            ren_q     <= ren_d;
        end
    end

    rptr_empty_fwft_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .rclk     (rclk),
        .rrstn    (rrstn),
        .fill     (ren_q),
        .fill_dat (mem_rdata),
        .rready   (rready),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .occ      (occ)
    );

    assign rptr    = rptr_q;
    assign raddr   = rbin_q[ASIZE-1:0];
    assign rempty  = rempty_q;
    assign raempty = raempty_q;
    assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Directed bench for rptr_empty_fwft with a registered-read RAM model.
`timescale 1ns/1ps
module tb_rptr_empty_fwft;

    localparam int AS = 4;
    localparam int DS = 8;

    logic          rclk;
    logic          rrstn;
    logic [AS:0]   r_wptr;
    logic [AS:0]   rptr;
    logic [AS-1:0] raddr;
    logic          mem_ren;
    logic [DS-1:0] mem_rdata;
    logic [DS-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rempty;
    logic          raempty;
    logic [AS:0]   rlevel;

    logic [DS-1:0] ram [16];
    int nvec = 0;
    int nerr = 0;

    rptr_empty_fwft #(.ASIZE(AS), .DSIZE(DS), .AE_THRESH(2)) dut (
        .rclk      (rclk),
        .rrstn     (rrstn),
        .r_wptr    (r_wptr),
        .rptr      (rptr),
        .raddr     (raddr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (mem_ren) mem_rdata <= ram[raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge rclk);
    endtask

    task automatic rst_pulse();
        rrstn  = 1'b0;
        r_wptr = '0;
        rready = 1'b0;
        tick();
        rrstn = 1'b1;
        tick();
    endtask

    function automatic logic [AS:0] g(input int b);
        logic [AS:0] v;
        v = b[AS:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [DS-1:0] wdat(input int k);
        int t;
        t = k * 37 + 11;
        return t[DS-1:0];
    endfunction

    initial begin
        int cnt, first, last, pulses, wb, cons, step, toggles, maxlvl, bad;
        logic prev_msb;

        rrstn  = 1'b0;
        r_wptr = 5'b01100;
        rready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 8'hA0 + 8'(i);
        tick();
        tick();

        chk("rst_rptr",    32'(rptr),    0);
        chk("rst_rempty",  32'(rempty),  1);
        chk("rst_raempty", 32'(raempty), 1);
        chk("rst_rlevel",  32'(rlevel),  0);
        chk("rst_rvalid",  32'(rvalid),  0);
        chk("rst_mem_ren", 32'(mem_ren), 0);
        chk("rst_rdata",   32'(rdata),   0);

        r_wptr = '0;
        rrstn  = 1'b1;
        tick();
        chk("idle_rempty",  32'(rempty),  1);
        chk("idle_mem_ren", 32'(mem_ren), 0);

        // single word
        r_wptr = 5'b00001;
        tick();
        chk("one_rempty0",  32'(rempty),  0);
        chk("one_ren",      32'(mem_ren), 1);
        chk("one_raddr",    32'(raddr),   0);
        chk("one_level",    32'(rlevel),  1);
        chk("one_raempty",  32'(raempty), 1);
        tick();
        chk("one_rempty1",  32'(rempty),  1);
        chk("one_ren_off",  32'(mem_ren), 0);
        chk("one_rvalid_e", 32'(rvalid),  0);
        tick();
        chk("one_rvalid",   32'(rvalid),  1);
        chk("one_rdata",    32'(rdata),   32'h A0);
        tick();
        tick();
        chk("one_hold_vld", 32'(rvalid),  1);
        chk("one_hold_dat", 32'(rdata),   32'h A0);
        chk("one_hold_ren", 32'(mem_ren), 0);
        rready = 1'b1;
        tick();
        chk("one_popped",   32'(rvalid),  0);
        rready = 1'b0;

        // burst of 8 with rready held high
        rst_pulse();
        r_wptr = 5'b01100;
        rready = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (rvalid) begin
                chk($sformatf("burst_d%0d", cnt), 32'(rdata), 32'(8'hA0 + cnt));
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        chk("burst_cnt",    cnt, 8);
        chk("burst_first",  first, 3);
        chk("burst_span",   last - first + 1, 8);
        chk("burst_rptr",   32'(rptr),   32'b01100);
        chk("burst_rempty", 32'(rempty), 1);

        // backpressure then drain
        rst_pulse();
        r_wptr = 5'b01100;
        rready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_ren) pulses++;
        end
        chk("bp_pulses",  pulses, 2);
        chk("bp_level",   32'(rlevel),  6);
        chk("bp_raempty", 32'(raempty), 0);
        chk("bp_rvalid",  32'(rvalid),  1);
        chk("bp_rdata",   32'(rdata),   32'h A0);
        rready = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (rvalid) begin
                chk($sformatf("bp_d%0d", cnt), 32'(rdata), 32'(8'hA0 + cnt));
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
            tick();
        end
        chk("bp_cnt",    cnt, 8);
        chk("bp_first",  first, 0);
        chk("bp_span",   last - first + 1, 8);
        chk("bp_rempty", 32'(rempty), 1);

        // 40 words across two pointer wraps, random consumer
        rst_pulse();
        wb = 0; cons = 0; toggles = 0; maxlvl = 0;
        prev_msb = rptr[AS];
        for (int cyc = 0; cyc < 1000 && cons < 40; cyc++) begin
            rready = ($urandom_range(0, 3) != 0);
            if (rvalid && rready) begin
                chk($sformatf("wrap_d%0d", cons), 32'(rdata), 32'(wdat(cons)));
                cons++;
            end
            if (int'(rlevel) > maxlvl) maxlvl = int'(rlevel);
            if (rptr[AS] != prev_msb) toggles++;
            prev_msb = rptr[AS];
            step = (40 - wb < 3) ? 40 - wb : 3;
            if (step > 0 && wb + step - cons <= 16 && $urandom_range(0, 1) == 1) begin
                for (int k = 0; k < step; k++) ram[(wb + k) % 16] = wdat(wb + k);
                wb += step;
                r_wptr = g(wb);
            end
            tick();
        end
        chk("wrap_cons",    cons, 40);
        chk("wrap_toggles", toggles, 2);
        chk("wrap_lvl_ok",  32'(maxlvl <= 16), 1);
        chk("wrap_rptr",    32'(rptr),   32'b01100);
        chk("wrap_rempty",  32'(rempty), 1);
        chk("wrap_level",   32'(rlevel), 0);

        // reset while buffer is full
        rst_pulse();
        r_wptr = 5'b01100;
        rready = 1'b0;
        repeat (6) tick();
        chk("mid_pre_vld", 32'(rvalid), 1);
        rrstn = 1'b0;
        #1;
        chk("mid_rvalid",  32'(rvalid),  0);
        chk("mid_rempty",  32'(rempty),  1);
        chk("mid_mem_ren", 32'(mem_ren), 0);
        chk("mid_rlevel",  32'(rlevel),  0);
        chk("mid_rdata",   32'(rdata),   0);
        tick();
        r_wptr = '0;
        tick();
        rrstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_ren || rvalid) bad++;
        end
        chk("mid_quiet",  bad, 0);
        chk("mid_rempty2", 32'(rempty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
